regfile_mp: RTL
===============

# regfile_mp

Parametrised multi-read-port register file for the MIPS datapath, succeeding the fixed 2-read, 32x32 register file. Adds configurable width, depth and read-port count, a per-register write-protect mask, and a dedicated link-write port for `jal`. A hardware init sequencer loads the architectural reset image one entry per cycle after reset, so the array needs no asynchronous reset. Sits between decode (read ports) and writeback (write port); `Ready` gates pipeline start.

## Interface

Parameters:
- `DATA_W`, 32, register width in bits.
- `ADDR_W`, 5, address width; depth `DEPTH = 2**ADDR_W`.
- `NUM_READ`, 2, number of independent combinational read ports (1..4).
- `SP_REG`, 29, stack-pointer index.
- `SP_INIT`, 16380, stack-pointer reset image.
- `LINK_REG`, 31, return-address register index.
- `INIT_BASE`, 100, offset for general-register reset image.
- `PROTECT_MASK`, 32'h8C000001, bit i set means the main write port cannot write register i (default protects 0, 26, 27, 31).

Ports:
- `Clk`  in  1  clock, rising-edge active.
- `Rst_n`  in  1  asynchronous active-low reset.
- `ReadAddr`  in  NUM_READ*ADDR_W  packed read addresses; port k is `[k*ADDR_W +: ADDR_W]`.
- `ReadData`  out  NUM_READ*DATA_W  packed read data, same packing.
- `RegWrite`  in  1  main write enable.
- `WAddr`  in  ADDR_W  main write address.
- `WData`  in  DATA_W  main write data.
- `jal`  in  1  link write enable.
- `return_address`  in  DATA_W  link write data, written to `LINK_REG`.
- `v0`, `v1`  out  DATA_W each  continuous views of registers 2 and 3.
- `Ready`  out  1  high once the init sequence has completed.

## Operation

- FSM states: INIT, RUN.
- `Rst_n` low: FSM -> INIT, init counter -> 0, `Ready` -> 0. All `ReadData`, `v0` and `v1` are forced to 0 while `Ready` = 0.
- INIT: each rising edge writes `image(cnt)` to `Registers[cnt]`, then `cnt++`. On the edge that writes `DEPTH-1`, the FSM moves to RUN and `Ready` -> 1.
- Reset image:
  - 0 for index 0, 1, 26, 27, 28, 30 and `LINK_REG`.
  - `SP_INIT` for `SP_REG`.
  - `i + INIT_BASE` for 2..25.
  - 0 for any index >= 32.
  - Values are truncated to `DATA_W`.
- RUN, main write: on a rising edge with `RegWrite` = 1 and `PROTECT_MASK[WAddr]` = 0, `Registers[WAddr] <= WData`. Protected addresses are silently dropped. For `DEPTH` > 32, mask bits beyond 31 read as 0 (unprotected).
- RUN, link write: on a rising edge with `jal` = 1, `Registers[LINK_REG] <= return_address`. This port ignores the protect mask.
- Simultaneous main and link writes to `LINK_REG`:
  - With the default mask, the main write is dropped.
  - If `LINK_REG` is unprotected, the link write wins.
- Simultaneous writes to different addresses both commit.
- `RegWrite` and `jal` are ignored in INIT; no write is queued.
- Reads are combinational from the array (see Configuration for same-cycle bypass). All read ports are independent; any ports may address the same register.
- Reset mid-operation: `Rst_n` low at any time aborts RUN or INIT immediately. On release, a full re-init runs and all prior contents are overwritten with the reset image.

## Timing

- After `Rst_n` deasserts, `Ready` rises after exactly `DEPTH` rising edges (32 with defaults).
- Write latency: a write commits at the rising edge. Read ports show the new value in the cycle after that edge, or the same cycle with bypass.
- Read latency: 0 cycles (combinational address -> data).
- `Ready` is registered and glitch-free. It changes only on a rising edge or on asynchronous reset.

## Configuration

- `REGFILE_BYPASS_EN` defined: write-through forwarding.
  - If a read port addresses a register being written this cycle (accepted main write or link write), `ReadData` returns the incoming data combinationally.
  - The link write takes precedence when both target the same address.
  - `v0` and `v1` are also bypassed.
- Not defined: reads return the array contents only. The datapath must tolerate one-cycle write-to-read visibility (the split-cycle/hazard-unit path).

## Test plan

- Reset then idle: `Ready` = 0 for 32 edges and 1 after. Reads return reg5 = 105, reg25 = 125, reg29 = 16380, reg0 = 0, reg31 = 0; `v0` = 102, `v1` = 103.
- Main write `WAddr` = 8, `WData` = 0xDEADBEEF: port 0 and port 1 both read 0xDEADBEEF next cycle. Writes to 0, 26, 27 and 31 leave them at 0.
- `jal` = 1 with `return_address` = 0x0040_0010 and `RegWrite` = 1 to reg 31 with 0x1234 in the same edge: reg31 = 0x0040_0010. Simultaneous `jal` plus main write to reg 9 commits both.
- Same-cycle read of reg 8 while writing 0x55 to it:
  - With `REGFILE_BYPASS_EN`: reads 0x55 that cycle.
  - Without: reads the old value, 0x55 the next cycle.
- Writes issued during INIT (`RegWrite` = 1 to reg 4 with 0xFF): after `Ready`, reg4 = 104.
- Write reg 8 = 0xDEADBEEF, pulse `Rst_n` low mid-run: outputs 0 and `Ready` = 0 immediately. After 32 edges, reg8 = 108.

Source files
------------

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with write-protect mask, link-write port and
// a post-reset init sequencer. Optional write-through forwarding: define REGFILE_BYPASS_EN.
module regfile_mp #(
    parameter int unsigned  DATA_W       = 32,
    parameter int unsigned  ADDR_W       = 5,
    parameter int unsigned  NUM_READ     = 2,
    parameter int unsigned  SP_REG       = 29,
    parameter int unsigned  SP_INIT      = 16380,
    parameter int unsigned  LINK_REG     = 31,
    parameter int unsigned  INIT_BASE    = 100,
    parameter logic [31:0]  PROTECT_MASK = 32'h8C00_0001
) (
    input  logic                         Clk,
    input  logic                         Rst_n,
    input  logic [NUM_READ*ADDR_W-1:0]   ReadAddr,
    output logic [NUM_READ*DATA_W-1:0]   ReadData,
    input  logic                         RegWrite,
    input  logic [ADDR_W-1:0]            WAddr,
    input  logic [DATA_W-1:0]            WData,
    input  logic                         jal,
    input  logic [DATA_W-1:0]            return_address,
    output logic [DATA_W-1:0]            v0,
    output logic [DATA_W-1:0]            v1,
    output logic                         Ready
);

    localparam int unsigned     DEPTH    = 2 ** ADDR_W;
    localparam int unsigned     NUM_VIEW = NUM_READ + 2;
    localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e             state;
    logic [ADDR_W-1:0]  cnt;
    logic [DATA_W-1:0]  regs [DEPTH];
    logic               main_prot;
    logic               main_we;
    logic               link_we;

    function automatic logic [DATA_W-1:0] image(input logic [ADDR_W-1:0] idx);
        int unsigned i;
        i = 32'(idx);
        if (i == LINK_REG)        return '0;
        if (i == SP_REG)          return DATA_W'(SP_INIT);
        if (i >= 2 && i <= 25)    return DATA_W'(i + INIT_BASE);
        return '0;
    endfunction

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= StInit;
            cnt   <= '0;
            Ready <= 1'b0;
        end else begin
            case (state)
                StInit: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == ADDR_W'(DEPTH - 1)) begin
                        state <= StRun;
                        Ready <= 1'b1;
                    end
                end
                StRun: ;
                default: state <= StInit;
            endcase
        end
    end

    // Shift past bit 31 yields zero, so addresses beyond the mask are unprotected.
    always_comb begin
        main_prot = |(PROTECT_MASK & (32'd1 << WAddr));
        main_we   = (state == StRun) && RegWrite && !main_prot;
        link_we   = (state == StRun) && jal;
    end

    // Array has no reset; the init sequencer loads the image. Link write is last so it wins.
    always_ff @(posedge Clk) begin
        if (state == StInit) begin
            regs[cnt] <= image(cnt);
        end else begin
            if (main_we) regs[WAddr]     <= WData;
            if (link_we) regs[LINK_ADDR] <= return_address;
        end
    end

    logic [ADDR_W-1:0] view_addr [NUM_VIEW];
    logic [DATA_W-1:0] view_data [NUM_VIEW];

    for (genvar k = 0; k < NUM_READ; k++) begin : g_port
        assign view_addr[k]                    = ReadAddr[k*ADDR_W +: ADDR_W];
        assign ReadData[k*DATA_W +: DATA_W]    = view_data[k];
    end
    assign view_addr[NUM_READ]     = ADDR_W'(2);
    assign view_addr[NUM_READ + 1] = ADDR_W'(3);
    assign v0 = view_data[NUM_READ];
    assign v1 = view_data[NUM_READ + 1];

    for (genvar k = 0; k < NUM_VIEW; k++) begin : g_view
        logic [DATA_W-1:0] d;
        always_comb begin
            d = regs[view_addr[k]];
`ifdef REGFILE_BYPASS_EN
            if (main_we && view_addr[k] == WAddr)     d = WData;
            if (link_we && view_addr[k] == LINK_ADDR) d = return_address;
`endif
            if (!Ready) d = '0;
        end
        assign view_data[k] = d;
    end

endmodule
